// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C controller.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK, REG, RSTART, WDATA, RDATA, MACK, STOP
   } state_t;

   localparam logic [1:0] MODE_1B  = 2'd0;
   localparam logic [1:0] MODE_2B  = 2'd1;
   localparam logic [1:0] MODE_REG = 2'd2;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Modes 1 and 3 both move two data bytes.
   function automatic logic is_two_byte(input logic [1:0] m);
      return (m == MODE_2B) || (m == 2'd3);
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period strobe: one-clk pulse every CLKS_PER_QUARTER cycles,
// restarted from zero whenever hold is asserted.
module i2c_quarter_tick #(
   parameter int CLKS_PER_QUARTER = 1250
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   output logic tick
);

   localparam int CW = (CLKS_PER_QUARTER > 2) ? $clog2(CLKS_PER_QUARTER) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(CLKS_PER_QUARTER - 1));

   // Free-running divider, cleared while held or on wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (hold || tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: one register-addressed read or write of
// zero, one or two data bytes per request. Each bit is four quarters; SDA
// only changes while SCL is low except inside START/RSTART/STOP.
module i2c_controller
   import i2c_pkg::*;
#(
   parameter int CLKS_PER_QUARTER = 1250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [6:0]  slave_address,
   input  logic [7:0]  target_register,
   input  logic        rw,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        scl,
   inout  wire         sda,
   output logic        busy
);

   state_t      state, state_n, ack_src, ack_src_n;
   logic [1:0]  q, q_n;
   logic [2:0]  bit_cnt, bit_n;
   logic        byte_sel, byte_n, rd_phase, rd_phase_n, nack, nack_n;
   logic [7:0]  tx, tx_n;
   logic [15:0] rx, rx_n, dout_n;
   logic [1:0]  mode_l, mode_n;
   logic [6:0]  addr_l, addr_n;
   logic [7:0]  reg_l, reg_n;
   logic        rw_l, rw_n;
   logic [15:0] din_l, din_n;
   logic        scl_n, sda_low, sda_low_n, busy_n, last_rd_n, tick, sda_in, mid_n;

   assign sda    = sda_low ? 1'b0 : 1'bz;
   assign sda_in = sda;

   i2c_quarter_tick #(.CLKS_PER_QUARTER(CLKS_PER_QUARTER)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .hold (state == IDLE),
      .tick (tick)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_n = state; q_n = q; bit_n = bit_cnt; byte_n = byte_sel;
      rd_phase_n = rd_phase; nack_n = nack; ack_src_n = ack_src;
      tx_n = tx; rx_n = rx; dout_n = dout;
      mode_n = mode_l; addr_n = addr_l; reg_n = reg_l; rw_n = rw_l; din_n = din_l;
      case (state)
         IDLE: if (en) begin
            state_n = START; q_n = 2'd0; byte_n = 1'b0; rd_phase_n = 1'b0;
            mode_n = mode; addr_n = slave_address; reg_n = target_register;
            rw_n = rw; din_n = din;
         end
         START: if (tick) begin
            if (q == 2'd2) begin
               state_n = ADDR; q_n = 2'd0; bit_n = 3'd7; tx_n = {addr_l, RW_WRITE};
            end else
               q_n = q + 2'd1;
         end
         RSTART: if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd3) begin
               state_n = ADDR; bit_n = 3'd7; tx_n = {addr_l, RW_READ}; rd_phase_n = 1'b1;
            end
         end
         ADDR, REG, WDATA: if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd3) begin
               if (bit_cnt == 3'd0) begin
                  state_n = ACK; ack_src_n = state;
               end else
                  bit_n = bit_cnt - 3'd1;
            end
         end
         ACK: if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd1) nack_n = sda_in;
            if (q == 2'd3) begin
               bit_n = 3'd7;
               if (nack)
                  state_n = STOP;
               else begin
                  case (ack_src)
                     ADDR: begin
                        if (rd_phase) state_n = RDATA;
                        else begin state_n = REG; tx_n = reg_l; end
                     end
                     REG: begin
                        if (mode_l == MODE_REG) state_n = STOP;
                        else if (rw_l == RW_WRITE) begin
                           state_n = WDATA; byte_n = 1'b0;
                           tx_n = is_two_byte(mode_l) ? din_l[15:8] : din_l[7:0];
                        end else
                           state_n = RSTART;
                     end
                     default: begin
                        if (is_two_byte(mode_l) && !byte_sel) begin
                           state_n = WDATA; tx_n = din_l[7:0]; byte_n = 1'b1;
                        end else
                           state_n = STOP;
                     end
                  endcase
               end
            end
         end
         RDATA: if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd1) rx_n = {rx[14:0], sda_in};
            if (q == 2'd3) begin
               if (bit_cnt == 3'd0) state_n = MACK;
               else bit_n = bit_cnt - 3'd1;
            end
         end
         MACK: if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd3) begin
               if (!is_two_byte(mode_l) || byte_sel) begin
                  state_n = STOP;
                  dout_n = (mode_l == MODE_1B) ? {8'h00, rx[7:0]} : rx;
               end else begin
                  state_n = RDATA; bit_n = 3'd7; byte_n = 1'b1;
               end
            end
         end
         STOP: begin
            // SDA was released on entry to q2; leave on the very next clk.
            if (q == 2'd2) begin
               state_n = IDLE; q_n = 2'd0;
            end else if (tick)
               q_n = q + 2'd1;
         end
         default: state_n = IDLE;
      endcase

      // Pin levels for the state being entered.
      last_rd_n = !is_two_byte(mode_n) || byte_n;
      mid_n     = (q_n == 2'd1) || (q_n == 2'd2);
      scl_n     = 1'b1;
      sda_low_n = 1'b0;
      case (state_n)
         START:            begin scl_n = (q_n != 2'd2); sda_low_n = (q_n != 2'd0); end
         RSTART:           begin scl_n = mid_n; sda_low_n = q_n[1]; end
         ADDR, REG, WDATA: begin scl_n = mid_n; sda_low_n = !tx_n[bit_n]; end
         ACK, RDATA:       scl_n = mid_n;
         MACK:             begin scl_n = mid_n; sda_low_n = !last_rd_n; end
         STOP:             begin scl_n = (q_n != 2'd0); sda_low_n = (q_n != 2'd2); end
         default: ;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, datapath and pin registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE; ack_src <= IDLE; q <= '0; bit_cnt <= '0; byte_sel <= 1'b0;
         rd_phase <= 1'b0; nack <= 1'b0; tx <= '0; rx <= '0; dout <= '0;
         mode_l <= '0; addr_l <= '0; reg_l <= '0; rw_l <= 1'b0; din_l <= '0;
         scl <= 1'b1; sda_low <= 1'b0; busy <= 1'b0;
      end else begin
         state <= state_n; ack_src <= ack_src_n; q <= q_n; bit_cnt <= bit_n;
         byte_sel <= byte_n; rd_phase <= rd_phase_n; nack <= nack_n;
         tx <= tx_n; rx <= rx_n; dout <= dout_n;
         mode_l <= mode_n; addr_l <= addr_n; reg_l <= reg_n; rw_l <= rw_n; din_l <= din_n;
         scl <= scl_n; sda_low <= sda_low_n; busy <= busy_n;
      end
   end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a behavioural I2C slave/monitor.
module tb_i2c_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [6:0]  slave_address = 7'h49;
   logic [7:0]  target_register = 8'h96;
   logic        rw = 1'b0;
   logic [15:0] din = 16'h0000;
   logic [15:0] dout;
   logic        scl;
   logic        busy;
   wire         sda;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;

   always #5 clk = ~clk;

   i2c_controller #(.CLKS_PER_QUARTER(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .mode            (mode),
      .slave_address   (slave_address),
      .target_register (target_register),
      .rw              (rw),
      .din             (din),
      .dout            (dout),
      .scl             (scl),
      .sda             (sda),
      .busy            (busy)
   );

   // Slave model / bus monitor
   logic       slave_low = 1'b0;
   logic       slave_tx = 1'b0;
   logic       nack_addr = 1'b0;
   logic [7:0] sh = 8'h00;
   logic [7:0] cur = 8'h00;
   logic [8:0] last;
   int         bit_idx = 0;
   int         nbytes = 0;
   int         starts = 0;
   int         stops = 0;
   logic [8:0] lg[$];      // {byte, ack bit}
   logic [7:0] rd_q[$];

   assign sda = slave_low ? 1'b0 : 1'bz;
   pullup (sda);

   always @(negedge sda) if (scl === 1'b1) begin
      starts++; bit_idx = 0; nbytes = 0; slave_tx = 1'b0; slave_low = 1'b0;
   end

   always @(posedge sda) if (scl === 1'b1) stops++;

   always @(posedge scl) begin
      if (bit_idx < 8) sh = {sh[6:0], sda};
      else lg.push_back({sh, sda});
      bit_idx++;
   end

   always @(negedge scl) begin
      if (bit_idx == 8) begin
         if (slave_tx) slave_low = 1'b0;
         else          slave_low = !(nbytes == 0 && nack_addr);
      end else if (bit_idx == 9) begin
         if (nbytes == 0 && sh[0]) slave_tx = 1'b1;
         nbytes++; bit_idx = 0;
         last = lg[lg.size()-1];
         if (slave_tx && !last[0]) begin
            cur = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
            slave_low = !cur[7];
         end else
            slave_low = 1'b0;
      end else if (bit_idx >= 1 && bit_idx <= 7 && slave_tx) begin
         slave_low = !cur[7-bit_idx];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_mon();
      lg.delete(); starts = 0; stops = 0; bit_idx = 0; nbytes = 0;
      slave_tx = 1'b0; slave_low = 1'b0;
   endtask

   // Issue one request and return the number of clk edges busy stayed high.
   task automatic run(input logic [1:0] m, input logic r, input logic [15:0] d, output int c);
      @(negedge clk);
      mode = m; rw = r; din = d; slave_address = 7'h49; target_register = 8'h96; en = 1'b1;
      c = 0;
      for (int i = 0; i < 8 && busy !== 1'b1; i++) begin @(posedge clk); #1; end
      en = 1'b0;
      check("busy_rise", busy, 1);
      while (busy === 1'b1 && c < 3000) begin @(posedge clk); #1; c++; end
      check("busy_fall", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      $display("txn mode=%0d rw=%0d din=%h: busy %0d clks, %0d bytes, starts=%0d stops=%0d dout=%h",
               m, r, d, c, lg.size(), starts, stops, dout);
   endtask

   logic [8:0] exp_w[4];
   logic [8:0] exp_r[5];
   logic [8:0] exp_r0[4];

   initial begin
      exp_w  = '{{8'h92,1'b0}, {8'h96,1'b0}, {8'hAA,1'b0}, {8'hCC,1'b0}};
      exp_r  = '{{8'h92,1'b0}, {8'h96,1'b0}, {8'h93,1'b0}, {8'h5A,1'b0}, {8'h3C,1'b1}};
      exp_r0 = '{{8'h92,1'b0}, {8'h96,1'b0}, {8'h93,1'b0}, {8'hF0,1'b1}};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_dout", dout, 0);

      // Write, two bytes
      clear_mon();
      run(2'd1, 1'b0, 16'hAACC, cyc);
      check("w_cycles", cyc, 597);
      check("w_starts", starts, 1);
      check("w_stops", stops, 1);
      check("w_nbytes", lg.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("w_byte%0d", i), lg[i], exp_w[i]);
      check("w_dout", dout, 16'h0000);

      // Read, two bytes
      clear_mon();
      rd_q = '{8'h5A, 8'h3C};
      run(2'd1, 1'b1, 16'h0000, cyc);
      check("r2_starts", starts, 2);
      check("r2_stops", stops, 1);
      check("r2_nbytes", lg.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("r2_byte%0d", i), lg[i], exp_r[i]);
      check("r2_dout", dout, 16'h5A3C);

      // Read, one byte
      clear_mon();
      rd_q = '{8'hF0};
      run(2'd0, 1'b1, 16'hFFFF, cyc);
      check("r1_starts", starts, 2);
      check("r1_nbytes", lg.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("r1_byte%0d", i), lg[i], exp_r0[i]);
      check("r1_dout", dout, 16'h00F0);

      // Pointer write only, rw ignored
      clear_mon();
      run(2'd2, 1'b1, 16'h1234, cyc);
      check("p_starts", starts, 1);
      check("p_stops", stops, 1);
      check("p_nbytes", lg.size(), 2);
      check("p_byte0", lg[0], {8'h92, 1'b0});
      check("p_byte1", lg[1], {8'h96, 1'b0});
      check("p_dout", dout, 16'h00F0);

      // Address NACK aborts
      clear_mon();
      nack_addr = 1'b1;
      run(2'd1, 1'b1, 16'h0000, cyc);
      nack_addr = 1'b0;
      check("n_cycles", cyc, 165);
      check("n_nbytes", lg.size(), 1);
      check("n_byte0", lg[0], {8'h92, 1'b1});
      check("n_stops", stops, 1);
      check("n_dout", dout, 16'h00F0);

      // Reset mid-byte (SDA driven low by the master at that point)
      @(negedge clk);
      mode = 2'd1; rw = 1'b0; din = 16'hAACC; en = 1'b1;
      for (int i = 0; i < 8 && busy !== 1'b1; i++) begin @(posedge clk); #1; end
      en = 1'b0;
      check("m_busy", busy, 1);
      repeat (77) @(posedge clk);
      #1;
      check("m_sda_low", sda, 0);
      rst = 1'b1;
      #1;
      check("m_rst_scl", scl, 1);
      check("m_rst_sda", sda, 1);
      check("m_rst_busy", busy, 0);
      check("m_rst_dout", dout, 0);
      $display("txn reset mid-byte: scl=%b sda=%b busy=%b dout=%h", scl, sda, busy, dout);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      clear_mon();
      run(2'd0, 1'b0, 16'h0011, cyc);
      check("f_cycles", cyc, 453);
      check("f_starts", starts, 1);
      check("f_stops", stops, 1);
      check("f_nbytes", lg.size(), 3);
      check("f_byte0", lg[0], {8'h92, 1'b0});
      check("f_byte1", lg[1], {8'h96, 1'b0});
      check("f_byte2", lg[2], {8'h11, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
